mips_run_monitor: RTL and testbench

//  Parametrised run controller/monitor sitting beside the MIPS core in simulation and FPGA bring-up.

---
 rtl/mips_tb_pkg.sv | 13 +
 rtl/pc_history_ring.sv | 62 ++++++
 rtl/mips_run_monitor.sv | 129 ++++++++++++
 tb/tb_mips_run_monitor.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/mips_tb_pkg.sv
// Shared types and default parameter values for the MIPS run monitor.
// The monitor detects halts (jump-to-self), times out runaway programs and keeps a PC history.
package mips_tb_pkg;

   typedef enum logic [1:0] {IDLE, RUN, HALTED, TIMEOUT} run_state_e;

   localparam int DEF_PC_W        = 32;
   localparam int DEF_DEPTH       = 16;
   localparam int DEF_HALT_CYCLES = 4;
   localparam int DEF_MAX_CYCLES  = 10000;
   localparam int DEF_CNT_W       = 32;

endpackage

// File: rtl/pc_history_ring.sv
// Ring buffer of the most recent distinct PCs, read combinationally relative to the newest entry.
// Storage carries no reset; the valid count alone decides what is visible.
module pc_history_ring
   import mips_tb_pkg::*;
#(
   parameter int PC_W  = DEF_PC_W,
   parameter int DEPTH = DEF_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     clear,
   input  logic                     push,
   input  logic [PC_W-1:0]          din,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic [PC_W-1:0]          rd_data,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [PC_W-1:0] mem_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [AW-1:0]   rd_addr;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      cnt_d    = cnt_q;
      if (clear) begin
         wr_ptr_d = '0;
         cnt_d    = '0;
      end else if (push) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (cnt_q != CW'(DEPTH)) begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr_q <= '0;
         cnt_q    <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         cnt_q    <= cnt_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= din;
      end
   end

   // Pointer arithmetic wraps modulo DEPTH because DEPTH is a power of two.
   assign rd_addr = wr_ptr_q - AW'(1) - rd_idx;
   assign rd_data = ({1'b0, rd_idx} < cnt_q) ? mem_q[rd_addr] : '0;
   assign count   = cnt_q;

endmodule

// File: rtl/mips_run_monitor.sv
// Run controller beside the MIPS core: halt detection on a repeated PC, cycle watchdog,
// and a history of recent distinct PCs for post-mortem readout.
module mips_run_monitor
   import mips_tb_pkg::*;
#(
   parameter int PC_W        = DEF_PC_W,
   parameter int DEPTH       = DEF_DEPTH,
   parameter int HALT_CYCLES = DEF_HALT_CYCLES,
   parameter int MAX_CYCLES  = DEF_MAX_CYCLES,
   parameter int CNT_W       = DEF_CNT_W
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     start,
   input  logic [PC_W-1:0]          pc,
   input  logic [$clog2(DEPTH)-1:0] rd_idx,
   output logic                     busy,
   output logic                     halted,
   output logic                     timeout,
   output logic [CNT_W-1:0]         cycle_cnt,
   output logic [PC_W-1:0]          halt_pc,
   output logic [PC_W-1:0]          hist_pc,
   output logic [$clog2(DEPTH):0]   hist_cnt
);

   localparam int RL_W = $clog2(HALT_CYCLES + 1);

   run_state_e       state_q, state_d;
   logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d, cyc_inc;
   logic [PC_W-1:0]  last_pc_q, last_pc_d;
   logic             last_valid_q, last_valid_d;
   logic [RL_W-1:0]  run_len_q, run_len_d;
   logic             halted_q, halted_d;
   logic             timeout_q, timeout_d;
   logic [PC_W-1:0]  halt_pc_q, halt_pc_d;
   logic             ring_push, ring_clear;

   assign cyc_inc = cycle_cnt_q + CNT_W'(1);

   always_comb begin
      state_d      = state_q;
      cycle_cnt_d  = cycle_cnt_q;
      last_pc_d    = last_pc_q;
      last_valid_d = last_valid_q;
      run_len_d    = run_len_q;
      halted_d     = halted_q;
      timeout_d    = timeout_q;
      halt_pc_d    = halt_pc_q;
      ring_push    = 1'b0;
      ring_clear   = 1'b0;
      case (state_q)
         RUN: begin
            cycle_cnt_d = cyc_inc;
            if (!last_valid_q || (pc != last_pc_q)) begin
               ring_push    = 1'b1;
               run_len_d    = RL_W'(1);
               last_pc_d    = pc;
               last_valid_d = 1'b1;
            end else begin
               run_len_d = run_len_q + RL_W'(1);
            end
            // Halt is checked first so a simultaneous watchdog expiry reports as a halt.
            if (run_len_d == RL_W'(HALT_CYCLES)) begin
               state_d   = HALTED;
               halted_d  = 1'b1;
               halt_pc_d = pc;
            end else if (cyc_inc == CNT_W'(MAX_CYCLES)) begin
               state_d   = TIMEOUT;
               timeout_d = 1'b1;
            end
         end
         default: begin
            if (start) begin
               state_d      = RUN;
               cycle_cnt_d  = '0;
               run_len_d    = '0;
               last_valid_d = 1'b0;
               halted_d     = 1'b0;
               timeout_d    = 1'b0;
               halt_pc_d    = '0;
               ring_clear   = 1'b1;
            end
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         cycle_cnt_q  <= '0;
         last_pc_q    <= '0;
         last_valid_q <= 1'b0;
         run_len_q    <= '0;
         halted_q     <= 1'b0;
         timeout_q    <= 1'b0;
         halt_pc_q    <= '0;
      end else begin
         state_q      <= state_d;
         cycle_cnt_q  <= cycle_cnt_d;
         last_pc_q    <= last_pc_d;
         last_valid_q <= last_valid_d;
         run_len_q    <= run_len_d;
         halted_q     <= halted_d;
         timeout_q    <= timeout_d;
         halt_pc_q    <= halt_pc_d;
      end
   end

   pc_history_ring #(
      .PC_W  (PC_W),
      .DEPTH (DEPTH)
   ) u_ring (
      .clk     (clk),
      .rst     (rst),
      .clear   (ring_clear),
      .push    (ring_push),
      .din     (pc),
      .rd_idx  (rd_idx),
      .rd_data (hist_pc),
      .count   (hist_cnt)
   );

   assign busy      = (state_q == RUN);
   assign halted    = halted_q;
   assign timeout   = timeout_q;
   assign cycle_cnt = cycle_cnt_q;
   assign halt_pc   = halt_pc_q;

endmodule

// File: tb/tb_mips_run_monitor.sv
// Bench for mips_run_monitor: three parameterisations share clock, reset and PC stimulus;
// expected outputs are queued when a cycle is driven and compared one edge later.
module tb_mips_run_monitor;
   import mips_tb_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] pc = '0;
   logic [3:0]  rd_idx = '0;
   logic        start_a = 1'b0, start_b = 1'b0, start_c = 1'b0;

   always #5 clk = ~clk;

   logic        a_busy, a_halted, a_timeout;
   logic [31:0] a_cyc, a_hpc, a_hist;
   logic [4:0]  a_hcnt;
   logic        b_busy, b_halted, b_timeout;
   logic [31:0] b_cyc, b_hpc, b_hist;
   logic [2:0]  b_hcnt;
   logic        c_busy, c_halted, c_timeout;
   logic [31:0] c_cyc, c_hpc, c_hist;
   logic [4:0]  c_hcnt;

   mips_run_monitor #(.PC_W(32), .DEPTH(16), .HALT_CYCLES(4), .MAX_CYCLES(10000), .CNT_W(32)) u_a (
      .clk(clk), .rst(rst), .start(start_a), .pc(pc), .rd_idx(rd_idx),
      .busy(a_busy), .halted(a_halted), .timeout(a_timeout), .cycle_cnt(a_cyc),
      .halt_pc(a_hpc), .hist_pc(a_hist), .hist_cnt(a_hcnt));

   mips_run_monitor #(.PC_W(32), .DEPTH(4), .HALT_CYCLES(4), .MAX_CYCLES(20), .CNT_W(32)) u_b (
      .clk(clk), .rst(rst), .start(start_b), .pc(pc), .rd_idx(rd_idx[1:0]),
      .busy(b_busy), .halted(b_halted), .timeout(b_timeout), .cycle_cnt(b_cyc),
      .halt_pc(b_hpc), .hist_pc(b_hist), .hist_cnt(b_hcnt));

   mips_run_monitor #(.PC_W(32), .DEPTH(16), .HALT_CYCLES(4), .MAX_CYCLES(4), .CNT_W(32)) u_c (
      .clk(clk), .rst(rst), .start(start_c), .pc(pc), .rd_idx(rd_idx),
      .busy(c_busy), .halted(c_halted), .timeout(c_timeout), .cycle_cnt(c_cyc),
      .halt_pc(c_hpc), .hist_pc(c_hist), .hist_cnt(c_hcnt));

   typedef struct {
      logic        busy;
      logic        halted;
      logic        timeout;
      logic [31:0] cyc;
      logic [31:0] halt_pc;
      logic [31:0] hcnt;
      logic [31:0] hist_pc;
   } exp_t;

   typedef struct {
      logic        start;
      logic [31:0] pc;
      logic [3:0]  rd;
      exp_t        e;
   } vec_t;

   exp_t exp_q[$];
   vec_t tbl[12];
   int   n_vec = 0;
   int   n_bad = 0;

   function automatic exp_t mk(bit b, bit h, bit t, int cyc, logic [31:0] hpc, int hc,
                               logic [31:0] hp);
      exp_t e;
      e.busy = b; e.halted = h; e.timeout = t; e.cyc = cyc;
      e.halt_pc = hpc; e.hcnt = hc; e.hist_pc = hp;
      return e;
   endfunction

   function automatic exp_t actual(int sel);
      exp_t e;
      case (sel)
         0: e = mk(a_busy, a_halted, a_timeout, int'(a_cyc), a_hpc, int'(a_hcnt), a_hist);
         1: e = mk(b_busy, b_halted, b_timeout, int'(b_cyc), b_hpc, int'(b_hcnt), b_hist);
         default: e = mk(c_busy, c_halted, c_timeout, int'(c_cyc), c_hpc, int'(c_hcnt), c_hist);
      endcase
      return e;
   endfunction

   task automatic cmp(string tag, string fld, logic [31:0] got, logic [31:0] want);
      if (got !== want) begin
         n_bad++;
         $display("FAIL %s %s: got %h, expected %h", tag, fld, got, want);
      end
   endtask

   // Drive one cycle on instance sel, then compare the oldest queued expectation after the edge.
   task automatic step(int sel, logic st, logic [31:0] p, logic [3:0] r, exp_t e, string tag);
      exp_t got, want;
      start_a = (sel == 0) && st;
      start_b = (sel == 1) && st;
      start_c = (sel == 2) && st;
      pc      = p;
      rd_idx  = r;
      exp_q.push_back(e);
      @(posedge clk);
      #1;
      start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
      got  = actual(sel);
      want = exp_q.pop_front();
      n_vec++;
      cmp(tag, "busy",      32'(got.busy),    32'(want.busy));
      cmp(tag, "halted",    32'(got.halted),  32'(want.halted));
      cmp(tag, "timeout",   32'(got.timeout), 32'(want.timeout));
      cmp(tag, "cycle_cnt", got.cyc,          want.cyc);
      cmp(tag, "halt_pc",   got.halt_pc,      want.halt_pc);
      cmp(tag, "hist_cnt",  got.hcnt,         want.hcnt);
      cmp(tag, "hist_pc",   got.hist_pc,      want.hist_pc);
   endtask

   task automatic run_table(string tag);
      for (int i = 0; i < 12; i++) begin
         step(0, tbl[i].start, tbl[i].pc, tbl[i].rd, tbl[i].e, $sformatf("%s[%0d]", tag, i));
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      exp_t z;
      logic [31:0] p;
      int k;
      z = mk(0, 0, 0, 0, 0, 0, 0);

      // Scenario: 0,4,8,C then C held; start is raised once more mid-run and must be ignored.
      tbl[0]  = '{1'b1, 32'h0,  4'd0, mk(1, 0, 0, 0, 0,     0, 32'h0)};
      tbl[1]  = '{1'b0, 32'h0,  4'd0, mk(1, 0, 0, 1, 0,     1, 32'h0)};
      tbl[2]  = '{1'b0, 32'h4,  4'd0, mk(1, 0, 0, 2, 0,     2, 32'h4)};
      tbl[3]  = '{1'b0, 32'h8,  4'd0, mk(1, 0, 0, 3, 0,     3, 32'h8)};
      tbl[4]  = '{1'b0, 32'hC,  4'd0, mk(1, 0, 0, 4, 0,     4, 32'hC)};
      tbl[5]  = '{1'b1, 32'hC,  4'd0, mk(1, 0, 0, 5, 0,     4, 32'hC)};
      tbl[6]  = '{1'b0, 32'hC,  4'd0, mk(1, 0, 0, 6, 0,     4, 32'hC)};
      tbl[7]  = '{1'b0, 32'hC,  4'd0, mk(0, 1, 0, 7, 32'hC, 4, 32'hC)};
      tbl[8]  = '{1'b0, 32'h99, 4'd3, mk(0, 1, 0, 7, 32'hC, 4, 32'h0)};
      tbl[9]  = '{1'b0, 32'h99, 4'd1, mk(0, 1, 0, 7, 32'hC, 4, 32'h8)};
      tbl[10] = '{1'b0, 32'h99, 4'd2, mk(0, 1, 0, 7, 32'hC, 4, 32'h4)};
      tbl[11] = '{1'b0, 32'h99, 4'd4, mk(0, 1, 0, 7, 32'hC, 4, 32'h0)};

      // Reset and idle.
      rst = 1'b1;
      step(0, 0, 0, 0, z, "reset0");
      step(0, 0, 0, 0, z, "reset1");
      rst = 1'b0;
      for (int i = 0; i < 5; i++) step(0, 0, 32'h44, 0, z, $sformatf("idle%0d", i));
      step(1, 0, 0, 0, z, "idle_b");
      step(2, 0, 0, 0, z, "idle_c");

      // Halt detection with history readout.
      run_table("halt");

      // Watchdog: PC advances every cycle, MAX_CYCLES=20, DEPTH=4.
      step(1, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "to_start");
      for (k = 1; k <= 20; k++) begin
         p = 32'(4 * (k - 1));
         step(1, 0, p, 0, mk(k < 20, 0, k == 20, k, 0, (k < 4) ? k : 4, p),
              $sformatf("to%0d", k));
      end
      step(1, 1'b0, 32'h0, 4'd3, mk(0, 0, 1, 20, 0, 4, 32'h40), "to_hold");

      // Wrap: six distinct PCs then hold on DEPTH=4.
      step(1, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "wrap_start");
      for (k = 1; k <= 9; k++) begin
         p = (k <= 6) ? 32'(4 * (k - 1)) : 32'h14;
         step(1, 0, p, 0, mk(k < 9, k == 9, 0, k, (k == 9) ? 32'h14 : 32'h0,
                             (k < 4) ? k : 4, p), $sformatf("wrap%0d", k));
      end
      step(1, 0, 32'h0, 4'd0, mk(0, 1, 0, 9, 32'h14, 4, 32'h14), "wrap_rd0");
      step(1, 0, 32'h0, 4'd1, mk(0, 1, 0, 9, 32'h14, 4, 32'h10), "wrap_rd1");
      step(1, 0, 32'h0, 4'd2, mk(0, 1, 0, 9, 32'h14, 4, 32'h0C), "wrap_rd2");
      step(1, 0, 32'h0, 4'd3, mk(0, 1, 0, 9, 32'h14, 4, 32'h08), "wrap_rd3");

      // Halt and timeout on the same cycle: halt wins.
      step(2, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "tie_start");
      for (k = 1; k <= 4; k++) begin
         step(2, 0, 32'h40, 0, mk(k < 4, k == 4, 0, k, (k == 4) ? 32'h40 : 32'h0, 1, 32'h40),
              $sformatf("tie%0d", k));
      end

      // Reset in the middle of a run, then the halt scenario again.
      step(0, 1, 0, 0, mk(1, 0, 0, 0, 0, 0, 0), "mid_start");
      step(0, 0, 32'h0, 0, mk(1, 0, 0, 1, 0, 1, 32'h0), "mid1");
      step(0, 0, 32'h4, 0, mk(1, 0, 0, 2, 0, 2, 32'h4), "mid2");
      step(0, 0, 32'h8, 0, mk(1, 0, 0, 3, 0, 3, 32'h8), "mid3");
      rst = 1'b1;
      step(0, 1, 32'hC, 0, z, "mid_rst");
      rst = 1'b0;
      step(0, 0, 32'hC, 0, z, "mid_idle");
      run_table("rerun");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
